priority_scan_encoder: RTL and testbench

- Parametrised, sequential successor to the 16-to-4 priority encoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake.
- Emits the index of every set bit, one per output beat, in priority order, with last and none flags.
- Sits between a request-collection stage and a downstream consumer that needs all set positions, not just the winner.

---
 rtl/priority_scan_encoder_pkg.sv | 18 +
 rtl/priority_scan_encoder_if.sv | 28 ++
 rtl/priority_scan_encoder_find.sv | 43 ++++
 rtl/priority_scan_encoder.sv | 81 ++++++++
 tb/tb_priority_scan_encoder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/priority_scan_encoder_pkg.sv
// Shared types and helpers for the priority scan encoder.
package priority_enc_pkg;

  // Scan controller states.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Upper bound on the request width handled by the generic helpers below.
  localparam int MAX_WIDTH = 1024;

  // True when at most one bit of v is set. Callers zero-extend to MAX_WIDTH.
  function automatic logic at_most_one(input logic [MAX_WIDTH-1:0] v);
    return (v & (v - MAX_WIDTH'(1))) == '0;
  endfunction

endpackage

// File: rtl/priority_scan_encoder_if.sv
// Request/response handshake bundle for the priority scan encoder.
interface priority_scan_encoder_if #(
  parameter int WIDTH = 16,
  parameter int IDXW  = $clog2(WIDTH)
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_none;
  logic             busy;

  // Producer/consumer side (drives requests, takes beats).
  modport master (
    output flush, in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none, busy
  );

  // Encoder side.
  modport slave (
    input  flush, in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none, busy
  );
endinterface

// File: rtl/priority_scan_encoder_find.sv
// Combinational priority finder: index, found flag and one-hot of the winner.
module priority_find #(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1,
  parameter int IDXW      = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             found,
  output logic [WIDTH-1:0] onehot
);

  assign found = |vec;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      // Ascending sweep; the last set bit seen (highest) wins.
      always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (vec[i]) idx = IDXW'(i);
        end
      end
    end else begin : g_lsb
      // Descending sweep; the last set bit seen (lowest) wins.
      always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (vec[i]) idx = IDXW'(i);
        end
      end
    end
  endgenerate

  // One-hot of the winner; all zeros when nothing is set, so clearing is a no-op.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_onehot
      assign onehot[gi] = found && (idx == IDXW'(gi));
    end
  endgenerate

endmodule

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: accepts a request vector and emits the index of
// every set bit, one per beat, in priority order, flagging the last beat and
// the all-zero case.
module priority_scan_encoder
  import priority_enc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  priority_scan_encoder_if.slave bus
);

  localparam int IDXW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic             none_q;

  logic [IDXW-1:0]  find_idx;
  logic             find_found;
  logic [WIDTH-1:0] find_onehot;

  logic scanning;
  logic last_beat;
  logic beat;
  logic accept;
  logic ready;

  priority_find #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IDXW      (IDXW)
  ) u_find (
    .vec    (pending),
    .idx    (find_idx),
    .found  (find_found),
    .onehot (find_onehot)
  );

  // Handshake decode; a new vector may enter on the cycle the final beat leaves.
  always_comb begin
    scanning  = (state == SCAN);
    last_beat = scanning && at_most_one(MAX_WIDTH'(pending));
    beat      = scanning && bus.out_ready;
    ready     = !bus.flush && (!scanning || (beat && last_beat));
    accept    = bus.in_valid && ready;
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = scanning;
  assign bus.out_idx   = scanning ? find_idx : '0;
  assign bus.out_last  = last_beat;
  assign bus.out_none  = scanning && none_q;
  assign bus.busy      = scanning;

  // Scan FSM and pending register; flush wins over accept and beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      none_q  <= 1'b0;
    end else if (bus.flush) begin
      state   <= IDLE;
      pending <= '0;
      none_q  <= 1'b0;
    end else if (accept) begin
      state   <= SCAN;
      pending <= bus.in_vec;
      none_q  <= (bus.in_vec == '0);
    end else if (beat) begin
      pending <= pending & ~find_onehot;
      if (last_beat) begin
        state  <= IDLE;
        none_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed bench for priority_scan_encoder: a 16-bit MSB-first instance and an
// 8-bit LSB-first instance, table-driven vectors plus multi-cycle sequences.
module tb_priority_scan_encoder;

  typedef struct packed {
    logic [15:0] vec;
    logic [4:0]  nbeats;
    logic        none;
    logic [63:0] idxs;   // beat b expected index in nibble b
  } vec_t;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;

  int checks   = 0;
  int failures = 0;

  priority_scan_encoder_if #(.WIDTH(16)) bus_a ();
  priority_scan_encoder_if #(.WIDTH(8))  bus_b ();

  priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (bus_a)
  );

  priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one vector to dut_a with out_ready high and check every beat.
  task automatic run_a(input vec_t t);
    @(negedge clk);
    bus_a.in_valid  = 1'b1;
    bus_a.in_vec    = t.vec;
    bus_a.out_ready = 1'b1;
    chk("a_in_ready", 32'(bus_a.in_ready), 32'd1);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    for (int b = 0; b < 32'(t.nbeats); b++) begin
      chk("a_valid", 32'(bus_a.out_valid), 32'd1);
      chk("a_idx",   32'(bus_a.out_idx),   32'(t.idxs[4*b +: 4]));
      chk("a_last",  32'(bus_a.out_last),  32'(b == 32'(t.nbeats) - 1));
      chk("a_none",  32'(bus_a.out_none),  32'(t.none));
      $display("a vec=%04h beat=%0d idx=%0d last=%0b none=%0b", t.vec, b,
               bus_a.out_idx, bus_a.out_last, bus_a.out_none);
      @(negedge clk);
    end
    chk("a_end_valid", 32'(bus_a.out_valid), 32'd0);
    chk("a_end_busy",  32'(bus_a.busy),      32'd0);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{vec: 16'h8421, nbeats: 5'd4,  none: 1'b0, idxs: 64'h0000_0000_0000_05AF};
    tbl[1] = '{vec: 16'h0000, nbeats: 5'd1,  none: 1'b1, idxs: 64'h0};
    tbl[2] = '{vec: 16'hFFFF, nbeats: 5'd16, none: 1'b0, idxs: 64'h0123_4567_89AB_CDEF};
    tbl[3] = '{vec: 16'h0001, nbeats: 5'd1,  none: 1'b0, idxs: 64'h0};
    tbl[4] = '{vec: 16'h8000, nbeats: 5'd1,  none: 1'b0, idxs: 64'hF};
    tbl[5] = '{vec: 16'h0810, nbeats: 5'd2,  none: 1'b0, idxs: 64'h4B};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.flush = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_vec = '0; bus_a.out_ready = 1'b0;
    bus_b.flush = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_vec = '0; bus_b.out_ready = 1'b0;

    // Reset state, with a vector offered during reset that must be ignored.
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    bus_a.in_vec   = 16'h1234;
    @(negedge clk);
    chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_idx",   32'(bus_a.out_idx),   32'd0);
    chk("rst_last",  32'(bus_a.out_last),  32'd0);
    chk("rst_none",  32'(bus_a.out_none),  32'd0);
    chk("rst_busy",  32'(bus_a.busy),      32'd0);
    bus_a.in_valid = 1'b0;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus_a.out_valid), 32'd0);
    $display("reset done");

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) run_a(tbl[i]);

    // Stall: 0x0003, out_ready low for 3 cycles.
    @(negedge clk);
    bus_a.in_valid  = 1'b1;
    bus_a.in_vec    = 16'h0003;
    bus_a.out_ready = 1'b0;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 32'(bus_a.out_valid), 32'd1);
      chk("stall_idx",   32'(bus_a.out_idx),   32'd1);
      chk("stall_last",  32'(bus_a.out_last),  32'd0);
      chk("stall_ready", 32'(bus_a.in_ready),  32'd0);
      $display("stall cycle=%0d idx=%0d", c, bus_a.out_idx);
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    chk("stall_idx_go", 32'(bus_a.out_idx), 32'd1);
    @(negedge clk);
    chk("stall_idx2",  32'(bus_a.out_idx),  32'd0);
    chk("stall_last2", 32'(bus_a.out_last), 32'd1);
    @(negedge clk);
    chk("stall_end", 32'(bus_a.out_valid), 32'd0);
    $display("stall sequence done");

    // Back-to-back: 0x0010 then 0x0100 with no bubble.
    bus_a.in_valid = 1'b1;
    bus_a.in_vec   = 16'h0010;
    @(negedge clk);
    chk("b2b_idx1",  32'(bus_a.out_idx),  32'd4);
    chk("b2b_last1", 32'(bus_a.out_last), 32'd1);
    bus_a.in_vec = 16'h0100;
    #1;
    chk("b2b_ready", 32'(bus_a.in_ready), 32'd1);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    chk("b2b_valid2", 32'(bus_a.out_valid), 32'd1);
    chk("b2b_idx2",   32'(bus_a.out_idx),   32'd8);
    chk("b2b_last2",  32'(bus_a.out_last),  32'd1);
    @(negedge clk);
    chk("b2b_end", 32'(bus_a.out_valid), 32'd0);
    $display("back-to-back done");

    // Flush mid-scan of 0xFFFF after three beats, with a competing vector.
    bus_a.in_valid = 1'b1;
    bus_a.in_vec   = 16'hFFFF;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("fl_idx_before", 32'(bus_a.out_idx), 32'd12);
    bus_a.flush    = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_vec   = 16'hABCD;
    #1;
    chk("fl_ready", 32'(bus_a.in_ready), 32'd0);
    @(negedge clk);
    bus_a.flush    = 1'b0;
    bus_a.in_valid = 1'b0;
    chk("fl_valid", 32'(bus_a.out_valid), 32'd0);
    chk("fl_busy",  32'(bus_a.busy),      32'd0);
    chk("fl_idx",   32'(bus_a.out_idx),   32'd0);
    @(negedge clk);
    chk("fl_no_accept", 32'(bus_a.out_valid), 32'd0);
    $display("flush done");
    run_a(tbl[3]);

    // LSB-first 8-bit instance: 0xA0 gives 5 then 7.
    @(negedge clk);
    bus_b.in_valid  = 1'b1;
    bus_b.in_vec    = 8'hA0;
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    chk("b_idx1",  32'(bus_b.out_idx),  32'd5);
    chk("b_last1", 32'(bus_b.out_last), 32'd0);
    $display("b vec=a0 beat=0 idx=%0d", bus_b.out_idx);
    @(negedge clk);
    chk("b_idx2",  32'(bus_b.out_idx),  32'd7);
    chk("b_last2", 32'(bus_b.out_last), 32'd1);
    $display("b vec=a0 beat=1 idx=%0d", bus_b.out_idx);
    @(negedge clk);
    chk("b_end", 32'(bus_b.out_valid), 32'd0);

    // Reset mid-scan on the 8-bit instance.
    bus_b.in_valid = 1'b1;
    bus_b.in_vec   = 8'hFF;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    chk("brst_idx_before", 32'(bus_b.out_idx), 32'd1);
    #2;
    rst_b_n = 1'b0;
    #1;
    chk("brst_valid", 32'(bus_b.out_valid), 32'd0);
    chk("brst_busy",  32'(bus_b.busy),      32'd0);
    chk("brst_idx",   32'(bus_b.out_idx),   32'd0);
    @(negedge clk);
    rst_b_n = 1'b1;
    bus_b.in_valid = 1'b1;
    bus_b.in_vec   = 8'h01;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    chk("brst_after_idx",  32'(bus_b.out_idx),  32'd0);
    chk("brst_after_last", 32'(bus_b.out_last), 32'd1);
    $display("b reset sequence done idx=%0d", bus_b.out_idx);
    @(negedge clk);
    chk("brst_after_end", 32'(bus_b.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
